// File: rtl/sd_sector_buffer_pkg.sv
// sd_sector_buffer_pkg: shared sizes and write-FSM encoding
// for the ping-pong SD sector buffer.
package sd_sector_buffer_pkg;
  localparam int DEF_SECTOR_BYTES = 512;
  localparam int PTR_W = 9;
  localparam int ADDR_W = PTR_W + 1;
  localparam int RAM_DEPTH = 2 * DEF_SECTOR_BYTES;

  typedef enum logic {
    FILL = 1'b0,
    PAD  = 1'b1
  } wr_state_e;
endpackage

// File: rtl/sd_sector_buffer_if.sv
// sd_sector_buffer_if: byte producer handshake into the
// sector buffer (valid/ready).
interface sd_sector_buffer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/sd_sector_bank_ram.sv
// sd_sector_bank_ram: 1024x8 simple dual-port RAM holding
// both sector banks; registered read, one clock.
module sd_sector_bank_ram
  import sd_sector_buffer_pkg::*;
(
  input  logic              clk_peri,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [RAM_DEPTH];

  always_ff @(posedge clk_peri) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: ping-pong two-sector byte buffer feeding an
// SD block writer. Drop statistics under SD_SECTOR_BUFFER_STATS_EN.
module sd_sector_buffer
  import sd_sector_buffer_pkg::*;
#(
  parameter int         SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter logic [7:0] PAD_BYTE     = 8'h00
) (
  input  logic                clk_peri,
  input  logic                reset_n,
  sd_sector_buffer_if.slave   wr,
  input  logic                flush,
  output logic                sec_valid,
  input  logic [PTR_W-1:0]    rd_addr,
  output logic [7:0]          rd_data,
  input  logic                sec_done,
  output logic [PTR_W-1:0]    fill_level,
  output logic [1:0]          sec_count,
  output logic [15:0]         drop_cnt,
  input  logic                stats_clr
);
  wr_state_e        state;
  logic             wr_bank;
  logic             rd_bank;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [1:0]       bank_full;
  logic [1:0]       full_nxt;
  logic             accept;
  logic             pad_we;
  logic             we;
  logic             last;
  logic             set;
  logic             clr;
  logic [7:0]       wdata;

  assign wr.wr_ready = (state == FILL) && !bank_full[wr_bank];
  assign accept = wr.wr_valid && wr.wr_ready;
  assign pad_we = (state == PAD) && !bank_full[wr_bank];
  assign we     = accept || pad_we;
  assign wdata  = (state == PAD) ? PAD_BYTE : wr.wr_data;
  assign last   = wr_ptr == PTR_W'(SECTOR_BYTES - 1);
  assign set    = we && last;
  assign clr    = sec_done && bank_full[rd_bank];

  // ptr_nxt is the pointer after any same-cycle write; flush keys off it
  assign ptr_nxt = !we  ? wr_ptr :
                   last ? '0     : wr_ptr + 1'b1;

  always_comb begin
    full_nxt = bank_full;
    if (set) full_nxt[wr_bank] = 1'b1;
    if (clr) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      bank_full <= '0;
    end else begin
      wr_ptr    <= ptr_nxt;
      bank_full <= full_nxt;
      if (set) wr_bank <= ~wr_bank;
      if (clr) rd_bank <= ~rd_bank;
      unique case (state)
        FILL: if (flush && ptr_nxt != '0) state <= PAD;
        PAD:  if (set) state <= FILL;
      endcase
    end
  end

  sd_sector_bank_ram u_ram (
    .clk_peri (clk_peri),
    .reset_n  (reset_n),
    .we       (we),
    .waddr    ({wr_bank, wr_ptr}),
    .wdata    (wdata),
    .raddr    ({rd_bank, rd_addr}),
    .rdata    (rd_data)
  );

  assign sec_valid  = bank_full[rd_bank];
  assign fill_level = wr_ptr;
  assign sec_count  = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

`ifdef SD_SECTOR_BUFFER_STATS_EN
  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (stats_clr) begin
      drop_cnt <= '0;
    end else if (wr.wr_valid && !wr.wr_ready
                 && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stats_clr;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb_sd_sector_buffer: randomized bench against a queue-based
// model of completed sectors and the partial sector.
module tb_sd_sector_buffer;
`ifdef SD_SECTOR_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [7:0] PADB = 8'h00;
  typedef logic [7:0] sec_t [512];

  logic        clk_peri = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        sec_done = 1'b0;
  logic        stats_clr = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic        sec_valid;
  logic [7:0]  rd_data;
  logic [8:0]  fill_level;
  logic [1:0]  sec_count;
  logic [15:0] drop_cnt;

  sd_sector_buffer_if bus();

  sd_sector_buffer dut (
    .clk_peri   (clk_peri),
    .reset_n    (reset_n),
    .wr         (bus),
    .flush      (flush),
    .sec_valid  (sec_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .sec_done   (sec_done),
    .fill_level (fill_level),
    .sec_count  (sec_count),
    .drop_cnt   (drop_cnt),
    .stats_clr  (stats_clr)
  );

  always #5 clk_peri = ~clk_peri;

  sec_t       secq[$];
  logic [7:0] part[$];
  bit         padding;
  int         drops;
  logic [7:0] exp_rd;
  bit         rd_chk;
  int         tests = 0;
  int         fails = 0;

  function automatic bit m_ready();
    return !padding && secq.size() < 2;
  endfunction

  function automatic logic [28:0] m_status();
    return {m_ready(), secq.size() != 0, 2'(secq.size()),
            9'(part.size()), 16'(drops)};
  endfunction

  task automatic m_clear();
    secq.delete();
    part.delete();
    padding = 0;
    drops = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d,
                       input bit f, input bit dn,
                       input logic [8:0] a, input bit c = 1'b0);
    bit had;
    bit pad_old;
    bit rdy;
    sec_t tmp;
    bus.wr_valid = v;
    bus.wr_data = d;
    flush = f;
    sec_done = dn;
    rd_addr = a;
    stats_clr = c;
    rdy = m_ready();
    rd_chk = secq.size() > 0;
    if (rd_chk) exp_rd = secq[0][a];
    had = secq.size() > 0;
    pad_old = padding;
    if (STATS) begin
      if (c) drops = 0;
      else if (v && !rdy && drops < 65535) drops++;
    end
    if (v && rdy) part.push_back(d);
    else if (pad_old && secq.size() < 2) part.push_back(PADB);
    if (part.size() == 512) begin
      foreach (tmp[i]) tmp[i] = part[i];
      secq.push_back(tmp);
      part.delete();
      padding = 0;
    end
    if (f && !pad_old && part.size() != 0) padding = 1;
    if (had && dn) void'(secq.pop_front());
    @(posedge clk_peri);
    #1;
    bus.wr_valid = 1'b0;
    flush = 1'b0;
    sec_done = 1'b0;
    stats_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_clear();
    #2;
    @(negedge clk_peri);
    reset_n = 1'b1;
    @(posedge clk_peri);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_clear();
    #2;
    tests++;
    if ({bus.wr_ready, sec_valid, fill_level, sec_count} !== 13'h1000) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b val=%b fill=%0d cnt=%0d want 1 0 0 0",
               bus.wr_ready, sec_valid, fill_level, sec_count);
    end
    tests++;
    if (rd_data !== 8'h00 || drop_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_regs got rd_data=%h drop=%0d want 00 0", rd_data, drop_cnt);
    end
    do_reset();
  endtask

  task automatic test_sector_fill();
    do_reset();
    for (int i = 0; i < 512; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 9'd0);
      if (i == 510) begin
        tests++;
        if (sec_valid !== 1'b0) begin
          fails++;
          $display("FAIL fill_early_valid got %b want 0", sec_valid);
        end
      end
    end
    tests++;
    if (sec_valid !== 1'b1 || sec_count !== 2'd1) begin
      fails++;
      $display("FAIL fill_valid got val=%b cnt=%0d want 1 1", sec_valid, sec_count);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd5);
    tests++;
    if (rd_data !== 8'h05) begin
      fails++;
      $display("FAIL fill_read5 got %h want 05", rd_data);
    end
    tests++;
    if (fill_level !== 9'd0 || bus.wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_next_bank got fill=%0d rdy=%b want 0 1", fill_level, bus.wr_ready);
    end
  endtask

  task automatic test_flush_pad();
    int n;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 9'd0);
    n = 0;
    while (!bus.wr_ready && n < 1000) begin
      n++;
      cycle(1'b0, 8'h00, (n == 3), 1'b0, 9'd0);
    end
    tests++;
    if (n !== 502) begin
      fails++;
      $display("FAIL pad_ready_low got %0d cycles want 502", n);
    end
    tests++;
    if (sec_valid !== 1'b1 || sec_count !== 2'd1 || fill_level !== 9'd0) begin
      fails++;
      $display("FAIL pad_closed got val=%b cnt=%0d fill=%0d want 1 1 0",
               sec_valid, sec_count, fill_level);
    end
    for (int a = 9; a < 512; a++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'(a));
      tests++;
      if (rd_data !== ((a < 10) ? 8'hA5 : 8'h00)) begin
        fails++;
        $display("FAIL pad_read[%0d] got %h want %h", a, rd_data,
                 (a < 10) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 1024; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 9'd0);
    tests++;
    if (sec_count !== 2'd2 || bus.wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full got cnt=%0d rdy=%b want 2 0", sec_count, bus.wr_ready);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 9'd0);
    tests++;
    if (drop_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      fails++;
      $display("FAIL bp_drops got %0d want %0d", drop_cnt, STATS ? 3 : 0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b1);
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL bp_clear got %0d want 0", drop_cnt);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
    tests++;
    if (bus.wr_ready !== 1'b1 || sec_count !== 2'd1) begin
      fails++;
      $display("FAIL bp_release got rdy=%b cnt=%0d want 1 1", bus.wr_ready, sec_count);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'($urandom));
      tests++;
      if (rd_data !== exp_rd) begin
        fails++;
        $display("FAIL bp_read got %h want %h", rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] second [512];
    do_reset();
    for (int i = 0; i < 512; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 9'd0);
    foreach (second[i]) second[i] = 8'($urandom);
    for (int i = 0; i < 511; i++) cycle(1'b1, second[i], 1'b0, 1'b0, 9'd0);
    cycle(1'b1, second[511], 1'b0, 1'b1, 9'd0);
    tests++;
    if (sec_valid !== 1'b1 || sec_count !== 2'd1 || bus.wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL simul_state got val=%b cnt=%0d rdy=%b want 1 1 1",
               sec_valid, sec_count, bus.wr_ready);
    end
    for (int i = 0; i < 6; i++) begin
      automatic logic [8:0] a = (i == 0) ? 9'd511 : 9'($urandom);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
      tests++;
      if (rd_data !== second[a]) begin
        fails++;
        $display("FAIL simul_read[%0d] got %h want %h", a, rd_data, second[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] first;
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 9'd0);
    reset_n = 1'b0;
    m_clear();
    #1;
    tests++;
    if ({fill_level, sec_count, bus.wr_ready, sec_valid} !== 13'b0000000000010) begin
      fails++;
      $display("FAIL midreset got fill=%0d cnt=%0d rdy=%b val=%b want 0 0 1 0",
               fill_level, sec_count, bus.wr_ready, sec_valid);
    end
    @(negedge clk_peri);
    reset_n = 1'b1;
    @(posedge clk_peri);
    #1;
    first = 8'h5A;
    for (int i = 0; i < 511; i++) begin
      cycle(1'b1, (i == 0) ? first : 8'($urandom), 1'b0, 1'b0, 9'd0);
      if (i == 211) begin
        tests++;
        if (sec_valid !== 1'b0 || fill_level !== 9'd212) begin
          fails++;
          $display("FAIL midreset_stale got val=%b fill=%0d want 0 212", sec_valid, fill_level);
        end
      end
    end
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd0);
    tests++;
    if (sec_count !== 2'd1 || rd_data !== first) begin
      fails++;
      $display("FAIL midreset_new got cnt=%0d rd=%h want 1 %h", sec_count, rd_data, first);
    end
  endtask

  task automatic test_boundary();
    int n;
    do_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 9'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd0);
    tests++;
    if ({bus.wr_ready, sec_valid, fill_level, sec_count} !== 13'h1000) begin
      fails++;
      $display("FAIL bound_idle got rdy=%b val=%b fill=%0d cnt=%0d want 1 0 0 0",
               bus.wr_ready, sec_valid, fill_level, sec_count);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 1), 1'b0, 1'b0, 9'd0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 9'd0);
    tests++;
    if (fill_level !== 9'd6 || bus.wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL bound_flush_acc got fill=%0d rdy=%b want 6 0", fill_level, bus.wr_ready);
    end
    n = 1;
    while (!bus.wr_ready && n < 1000) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd0);
      if (!bus.wr_ready) n++;
    end
    tests++;
    if (n !== 506) begin
      fails++;
      $display("FAIL bound_pad_len got %0d want 506", n);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 9'd5);
    tests++;
    if (rd_data !== 8'h3C) begin
      fails++;
      $display("FAIL bound_read5 got %h want 3c", rd_data);
    end
  endtask

  task automatic test_random();
    logic [28:0] exp_s;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
            9'($urandom), $urandom_range(0, 199) == 0);
      exp_s = m_status();
      tests++;
      if ({bus.wr_ready, sec_valid, sec_count, fill_level, drop_cnt} !== exp_s) begin
        fails++;
        $display("FAIL rand_status[%0d] got %h want %h", i,
                 {bus.wr_ready, sec_valid, sec_count, fill_level, drop_cnt}, exp_s);
      end
      if (rd_chk) begin
        tests++;
        if (rd_data !== exp_rd) begin
          fails++;
          $display("FAIL rand_read[%0d] got %h want %h", i, rd_data, exp_rd);
        end
      end
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_sector_fill();
    test_flush_pad();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_sector_buffer.md
SD_SECTOR_BUFFER -- requirements
Module: sd_sector_buffer

Interface
REQ-001 SHALL provide parameter SECTOR_BYTES, default 512, meaning the bytes per bank, fixed to one SD block.
REQ-002 SHALL provide parameter PAD_BYTE, default 8'h00, meaning the fill value written on flush.
REQ-003 SHALL provide port clk_peri, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide the producer ports: wr_valid in 1 (byte offered); wr_data in 8 (byte); wr_ready out 1 (byte accepted this cycle when high with wr_valid).
REQ-006 SHALL provide port flush, input, 1 bit: pulse that pads and closes the partial sector.
REQ-007 SHALL provide port sec_valid, output, 1 bit: a full sector is available to the SD writer.
REQ-008 SHALL provide port rd_addr, input, 9 bits: byte index within the available sector.
REQ-009 SHALL provide port rd_data, output, 8 bits: byte at rd_addr, registered.
REQ-010 SHALL provide port sec_done, input, 1 bit: pulse releasing the available sector.
REQ-011 SHALL provide the status ports: fill_level out 9 (bytes in the sector being filled); sec_count out 2 (full sectors pending, 0..2).
REQ-012 SHALL provide the statistics ports: drop_cnt out 16 (bytes offered while not ready); stats_clr in 1 (clears drop_cnt).

Function
REQ-013 SHALL hold two banks of SECTOR_BYTES each (ping-pong), with state wr_bank, wr_ptr[8:0], rd_bank and bank_full[1:0].
REQ-014 SHALL run a write FSM with states FILL and PAD.
REQ-015 SHALL drive wr_ready = (state==FILL) && !bank_full[wr_bank].
REQ-016 SHALL, on accept, write wr_data to {wr_bank,wr_ptr} and increment wr_ptr.
REQ-017 SHALL, on the write to wr_ptr==511: set bank_full[wr_bank], toggle wr_bank and set wr_ptr to 0, all in the same edge.
REQ-018 SHALL, on flush in FILL with wr_ptr!=0 after any same-cycle accept, enter PAD. In PAD it writes PAD_BYTE one per cycle until index 511 is written, closes the bank per REQ-017 and returns to FILL.
REQ-019 SHALL ignore flush when the effective wr_ptr==0 or when already in PAD.
REQ-020 SHALL, when flush arrives with an accepted byte in the same cycle, store the byte first; padding starts the next cycle.
REQ-021 SHALL, in PAD with the target bank full, stall padding until that bank is released. (This cannot normally occur; it is listed for completeness.)
REQ-022 SHALL drive sec_valid = bank_full[rd_bank].
REQ-023 SHALL register rd_data from {rd_bank,rd_addr} with 1-cycle latency, independent of sec_valid.
REQ-024 SHALL, on sec_done with sec_valid high, clear bank_full[rd_bank] and toggle rd_bank; sec_valid updates the next cycle.
REQ-025 SHALL ignore sec_done while sec_valid is low.
REQ-026 SHALL permit a bank set and a bank clear in the same cycle; they always target different banks, and both take effect.
REQ-027 SHALL drive fill_level = wr_ptr and sec_count = bank_full[0] + bank_full[1], both registered-state derived.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear state (to FILL), wr_bank, rd_bank, wr_ptr, bank_full, rd_data and drop_cnt. Outputs are then wr_ready=1, sec_valid=0, fill_level=0, sec_count=0.
REQ-029 SHALL NOT initialise RAM contents on reset; reset mid-sector discards all buffered data.

Configuration
REQ-030 SHALL, with SD_SECTOR_BUFFER_STATS_EN defined, increment drop_cnt when wr_valid && !wr_ready, saturating at 16'hFFFF. stats_clr sets it to 0 and takes priority over the increment.
REQ-031 SHALL, without SD_SECTOR_BUFFER_STATS_EN, tie drop_cnt to 0 and ignore stats_clr; the ports remain present.

Structure
REQ-032 SHALL place the SECTOR_BYTES default, the FSM state encodings (FILL, PAD) and the pointer widths in the shared package sd_sector_buffer_pkg.
REQ-033 SHALL implement storage as one sub-module, sd_sector_bank_ram. It is a simple dual-port 1024x8 RAM (write port plus registered read port, single clock) and must infer BRAM.

Verification
REQ-034 SHALL cover the sector fill: 512 bytes of 0x00..0xFF twice, no stalls. Required response: sec_valid rises the cycle after the 512th accept, sec_count=1, and rd_addr=5 gives rd_data=0x05 one cycle later.
REQ-035 SHALL cover the flush pad: 10 bytes 0xA5, then a flush pulse. Required response: wr_ready is low for 502 cycles, sec_valid rises, rd_addr 9 gives 0xA5 and rd_addr 10..511 give 0x00.
REQ-036 SHALL cover backpressure: fill 1024 bytes with sec_done never asserted. Required response: sec_count=2, wr_ready=0, and with STATS_EN 3 further offered bytes give drop_cnt=3; a sec_done pulse restores wr_ready next cycle.
REQ-037 SHALL cover simultaneous events: the 512th accept of bank 1 in the same cycle as sec_done for bank 0. Required response: bank_full becomes 2'b10, sec_valid stays high and rd_bank=1.
REQ-038 SHALL cover reset mid-operation: assert reset_n low after 300 bytes. Required response: immediate fill_level=0, sec_count=0, wr_ready=1, and no stale sector presented afterwards.
REQ-039 SHALL cover flush at a boundary: flush with wr_ptr==0, and sec_done with sec_valid=0. Required response: no state change and no padding cycles.
